// File: rtl/vec_mem_sequencer.sv
// Sequencer for vector loads/stores: walks one lane per access over the scalar
// data-memory port with a req/ack handshake, stalling decode until the last lane.
module vec_mem_sequencer #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      is_store,
  input  logic                      is_half,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [LANES*DATA_W-1:0]   store_vec,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic                      mem_size,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [LANES*DATA_W-1:0]   load_vec,
  output logic                      vec_we,
  output logic                      done,
  output logic                      busy,
  output logic                      stall
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [IDX_W-1:0]          idx;
  logic                      op_store;
  logic                      op_half;
  logic [ADDR_W-1:0]         op_base;
  logic [LANES*DATA_W-1:0]   op_svec;

  logic                      last_lane;
  logic                      xfer_ack;
  logic [DATA_W-1:0]         lane_word;
  logic [DATA_W-1:0]         rdata_elem;
  logic [ADDR_W-1:0]         lane_off;

  assign last_lane  = (idx == IDX_W'(LANES - 1));
  assign xfer_ack   = (state == XFER) && mem_ack;
  assign lane_word  = op_svec[int'(idx)*DATA_W +: DATA_W];
  assign rdata_elem = op_half ? DATA_W'(mem_rdata[15:0]) : mem_rdata;
  assign lane_off   = ADDR_W'(idx) << (op_half ? 1 : 2);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output and the next state get a default before the case, so no
  // path leaves them unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_size  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    vec_we    = 1'b0;
    done      = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = start;
        if (start) state_nxt = XFER;
      end
      XFER: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_we   = op_store;
        mem_size = op_half;
        mem_addr = op_base + lane_off;
        if (op_store) mem_wdata = op_half ? DATA_W'(lane_word[15:0]) : lane_word;
        if (mem_ack && last_lane) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        vec_we    = !op_store;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: load_vec is a plain register bank, not a RAM, so it takes the async
  // reset like the rest of the state; a cleared result is visible after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      op_store <= 1'b0;
      op_half  <= 1'b0;
      op_base  <= '0;
      op_svec  <= '0;
      load_vec <= '0;
    end else if (state == IDLE && start) begin
      idx      <= '0;
      op_store <= is_store;
      op_half  <= is_half;
      op_base  <= base_addr;
      op_svec  <= store_vec;
    end else if (xfer_ack) begin
      if (!op_store) load_vec[int'(idx)*DATA_W +: DATA_W] <= rdata_elem;
      if (!last_lane) idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer: expected accesses are queued when an
// operation is issued and popped as the responder acknowledges each request.
module tb_vec_mem_sequencer;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          is_store;
  logic          is_half;
  logic [31:0]   base_addr;
  logic [127:0]  store_vec;
  logic          mem_req;
  logic          mem_we;
  logic          mem_size;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic [127:0]  load_vec;
  logic          vec_we;
  logic          done;
  logic          busy;
  logic          stall;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic        size;
    logic [31:0] wdata;
  } acc_t;

  acc_t         exp_q[$];
  logic [127:0] model_load = '0;
  int           n_cmp  = 0;
  int           n_fail = 0;

  vec_mem_sequencer #(.LANES(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .is_half   (is_half),
    .base_addr (base_addr),
    .store_vec (store_vec),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .load_vec  (load_vec),
    .vec_we    (vec_we),
    .done      (done),
    .busy      (busy),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one operation in the current cycle (cycle 0) and serves it with
  // wait_n wait states per lane; inject_cyc >= 1 pulses a rogue start then.
  task automatic run_op(input logic st, input logic hf, input logic [31:0] base,
                        input logic [127:0] sv, input logic [127:0] rd,
                        input int wait_n, input int inject_cyc);
    logic [31:0]  stride;
    logic [31:0]  lane;
    logic [127:0] exp_load;
    int           k;
    int           wcnt;
    bit           seen_done;
    stride   = hf ? 32'd2 : 32'd4;
    exp_load = model_load;
    for (int i = 0; i < 4; i++) begin
      lane = sv[i*32 +: 32];
      exp_q.push_back('{addr:  base + 32'(i) * stride,
                        we:    st,
                        size:  hf,
                        wdata: hf ? {16'h0, lane[15:0]} : lane});
      if (!st) exp_load[i*32 +: 32] = hf ? {16'h0, rd[i*32 +: 16]} : rd[i*32 +: 32];
    end
    check("busy_before_start", busy, 0);
    start = 1'b1; is_store = st; is_half = hf; base_addr = base; store_vec = sv;
    #1 check("stall_start_cycle", stall, 1);
    k = 0; wcnt = 0; seen_done = 0;
    for (int c = 1; c <= 100 && !seen_done; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      start   = (c == inject_cyc);
      if (start) {is_store, is_half, base_addr, store_vec} = {~st, ~hf, 32'h900, ~sv};
      #1;
      if (done) begin
        check("done_cycle", c, 5 + 4 * wait_n);
        check("vec_we", vec_we, !st);
        check("load_vec", load_vec, exp_load);
        check("stall_in_done", stall, 0);
        check("req_in_done", mem_req, 0);
        check("busy_in_done", busy, 1);
        seen_done = 1;
      end else begin
        check("stall_xfer", stall, 1);
        check("mem_req", mem_req, 1);
        if (mem_req) begin
          if (exp_q.size() == 0) begin
            check("extra_req", 1, 0);
          end else begin
            check("mem_addr", mem_addr, exp_q[0].addr);
            check("mem_we", mem_we, exp_q[0].we);
            check("mem_size", mem_size, exp_q[0].size);
            if (st) check("mem_wdata", mem_wdata, exp_q[0].wdata);
            if (wcnt == wait_n) begin
              mem_ack   = 1'b1;
              mem_rdata = rd[k*32 +: 32];
              void'(exp_q.pop_front());
              k++;
              wcnt = 0;
            end else begin
              wcnt++;
            end
          end
        end
      end
    end
    start = 1'b0;
    check("done_seen", seen_done, 1);
    check("lanes_acked", k, 4);
    model_load = exp_load;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; is_half = 1'b0;
    base_addr = '0; store_vec = '0; mem_ack = 1'b0; mem_rdata = '0;
    #12;
    check("reset_outputs",
          {mem_req, mem_we, mem_size, mem_addr, mem_wdata, vec_we, done, busy, stall}, 0);
    check("reset_load_vec", load_vec, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_busy", busy, 0);
    check("post_reset_stall", stall, 0);

    // VLDW, zero wait states
    run_op(1'b0, 1'b0, 32'h100, '0, {32'h44, 32'h33, 32'h22, 32'h11}, 0, -1);

    // VSTB, two wait cycles per lane; load_vec must be left untouched
    run_op(1'b1, 1'b1, 32'h200,
           {32'hDDDDEF01, 32'hCCCC9ABC, 32'hBBBB5678, 32'hAAAA1234}, '0, 2, -1);

    // VLDH with address wrap and zero-extension
    run_op(1'b0, 1'b1, 32'hFFFFFFFC, '0, {4{32'hDEADBEEF}}, 0, -1);

    // Rogue start in cycle 2 is ignored; the next op starts in cycle 6
    run_op(1'b0, 1'b0, 32'h500, '0, {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A}, 0, 2);
    run_op(1'b1, 1'b0, 32'h600,
           {32'h40404040, 32'h30303030, 32'h20202020, 32'h10101010}, '0, 1, -1);

    // Reset in the middle of a load, after lane 1 has been acknowledged
    exp_q.delete();
    start = 1'b1; is_store = 1'b0; is_half = 1'b0; base_addr = 32'h300;
    @(negedge clk);
    start = 1'b0;
    #1 check("mid_lane0_addr", mem_addr, 32'h300);
    mem_ack = 1'b1; mem_rdata = 32'h55;
    @(negedge clk);
    #1 check("mid_lane1_addr", mem_addr, 32'h304);
    mem_ack = 1'b1; mem_rdata = 32'h66;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("mid_partial_load", load_vec, {model_load[127:64], 32'h66, 32'h55});
    check("mid_lane2_addr", mem_addr, 32'h308);
    #1 rst_n = 1'b0;
    #1;
    check("mid_reset_req", mem_req, 0);
    check("mid_reset_load_vec", load_vec, 0);
    check("mid_reset_outputs",
          {mem_req, mem_we, mem_size, mem_addr, mem_wdata, vec_we, done, busy, stall}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_load = '0;
    #1;
    run_op(1'b0, 1'b0, 32'h400, '0, {32'h98, 32'h87, 32'h76, 32'h65}, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_mem_sequencer.md
# vec_mem_sequencer

Multi-cycle sequencer for the vector memory instructions VLDW, VLDH, VSTW and VSTB. Decode issues one `start` pulse per instruction. The block then walks the vector one lane at a time over the single scalar data-memory port, using a req/ack handshake. It stalls the pipeline until the last lane completes, then pulses the vector register write for loads. It sits beside the control unit and arbitrates nothing else: while busy, it owns the memory port.

## Interface
- `LANES`, 4: elements per vector register (≥2).
- `ADDR_W`, 32: memory address width.
- `DATA_W`, 32: element and memory data width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  decoded vector memory op valid this cycle.
- `is_store`  in  1  1 = VSTW/VSTB, 0 = VLDW/VLDH; sampled with `start`.
- `is_half`  in  1  1 = 16-bit elements (VLDH/VSTB), 0 = 32-bit; sampled with `start`.
- `base_addr`  in  ADDR_W  address of lane 0; sampled with `start`.
- `store_vec`  in  LANES*DATA_W  store source, lane i at bits [i*DATA_W +: DATA_W]; sampled with `start`.
- `mem_req`  out  1  access request.
- `mem_we`  out  1  1 = write.
- `mem_size`  out  1  0 = word, 1 = halfword.
- `mem_addr`  out  ADDR_W  access address.
- `mem_wdata`  out  DATA_W  write data.
- `mem_ack`  in  1  access complete this cycle.
- `mem_rdata`  in  DATA_W  read data, valid when `mem_ack`=1.
- `load_vec`  out  LANES*DATA_W  assembled load result, same lane packing as `store_vec`.
- `vec_we`  out  1  one-cycle write strobe for the vector register file (loads only).
- `done`  out  1  one-cycle completion pulse (loads and stores).
- `busy`  out  1  sequencer not idle.
- `stall`  out  1  freeze fetch/decode.

## Operation
- States: IDLE, XFER, DONE.
- IDLE:
  - `start`=1 latches `is_store`, `is_half`, `base_addr` and `store_vec`, clears lane index `idx`, and moves to XFER.
  - `start` in any other state is ignored; decode must not issue while `stall`=1.
- XFER:
  - `mem_req`=1, `mem_we`=`is_store`, `mem_size`=`is_half`.
  - `mem_addr` = base + idx*stride. Stride is 4 for words, 2 for halfwords. Address arithmetic is modulo 2^ADDR_W and wraps silently; alignment is not checked.
  - Store: `mem_wdata` = lane idx for words; for halfwords it is lane idx[15:0] zero-extended.
  - Request outputs hold stable until `mem_ack`=1 is sampled.
  - On ack for a load: lane idx of `load_vec` ← `mem_rdata` (word) or zero-extended `mem_rdata[15:0]` (half).
  - On ack, if idx < LANES-1: idx increments and the state stays XFER. If idx = LANES-1: go to DONE.
  - `mem_ack` is ignored whenever `mem_req`=0.
- DONE (exactly one cycle):
  - `done`=1, and `vec_we`=!`is_store`.
  - `mem_req`=0.
  - Next state is IDLE.
- Outputs:
  - `busy` = (state ≠ IDLE).
  - `stall` = (state = IDLE & `start`) | (state = XFER). This is combinational from `start`, so the issuing instruction freezes in its start cycle.
  - `stall` is 0 in DONE, so the pipeline advances in the same cycle the vector register is written.
- `load_vec` holds its value between operations. Store operations leave `load_vec` unchanged.
- Reset (asynchronous, any state, including mid-XFER):
  - State goes to IDLE; idx, `load_vec` and all latched operands are cleared to 0.
  - `mem_req`, `mem_we`, `mem_size`, `mem_addr`, `mem_wdata`, `vec_we`, `done`, `busy` and `stall` are all 0.
  - An in-flight access is abandoned; the memory side must tolerate a dropped request.

## Timing
- Cycle 0: `start` sampled.
- Cycle 1: first request.
- With zero wait states (ack in the request cycle): lane k is requested in cycle 1+k, DONE falls in cycle LANES+1, and a new `start` is accepted from cycle LANES+2.
- Each wait cycle (req=1, ack=0) adds exactly one cycle; there is no timeout.
- Latency start→done = LANES + 1 + total wait cycles.
- `load_vec` is updated at the clock edge following each ack and is fully valid in the DONE cycle, together with `vec_we`.
- Back-to-back operations cost one idle cycle between DONE and the next XFER.

## Test plan
- Reset values: assert `rst_n`=0 asynchronously mid-cycle → all outputs 0 immediately. Release reset with `start`=0 → `busy`=0 and `stall`=0.
- VLDW, zero-wait: base 0x100, ack every cycle, rdata = 0x11, 0x22, 0x33, 0x44 → addresses 0x100, 0x104, 0x108, 0x10C in cycles 1–4. `vec_we`=`done`=1 in cycle 5 with `load_vec`={0x44,0x33,0x22,0x11}. `stall`=1 in cycles 0–4 only.
- VSTB, wait states: base 0x200, `store_vec` lanes 0xAAAA1234…, ack delayed 2 cycles per lane → addresses 0x200, 0x202, 0x204, 0x206 with `mem_we`=1 and `mem_size`=1. `mem_wdata`=0x00001234 for lane 0, held stable during waits. `done` arrives in cycle 13 with `vec_we`=0.
- VLDH, zero-extension and wrap: base 0xFFFFFFFC, rdata 0xDEADBEEF on every ack → addresses 0xFFFFFFFC, 0xFFFFFFFE, 0x00000000, 0x00000002. Every lane of `load_vec` = 0x0000BEEF.
- Start while busy: pulse `start` with different operands in cycle 2 of a load → ignored; original addresses and result unchanged. A `start` in cycle 6 is accepted.
- Reset mid-XFER: drop `rst_n` after lane 1's ack → `mem_req` falls immediately and `load_vec`=0. A following VLDW starts again from lane 0.
